// File: rtl/seq_div64_if.sv
// Start/done handshake bundle between the arithmetic unit and the iterative divider.
interface seq_div64_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_zero;

  modport master (
    output start, A, B,
    input  ready, done, Q, R, div_zero
  );

  modport slave (
    input  start, A, B,
    output ready, done, Q, R, div_zero
  );
endinterface

// File: rtl/seq_div64.sv
// Iterative restoring divider, one quotient bit per clock via a WIDTH+1-bit trial subtract.
// Define DIV_SIGNED_EN for two's-complement operands (quotient truncates toward zero).
module seq_div64 #(
  parameter int WIDTH = 64
) (
  input logic        clk,
  input logic        rst,
  seq_div64_if.slave bus
);

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, rem, dvs;
  logic [WIDTH-1:0] dvd_nxt, rem_nxt;
  logic [WIDTH:0]   trial;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] quo, rmd;
  logic             dz;
  logic             accept;

  function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return (SIGNED_EN && v[WIDTH-1]) ? neg2(v) : v;
  endfunction

  function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH-1:0] r,
                                               input logic             b_in,
                                               input logic [WIDTH-1:0] d);
    return {r, b_in} - {1'b0, d};
  endfunction

  assign accept = (state == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.B == '0) ? DONE : CALC;
      CALC: if (cnt == CNT_LAST) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Trial subtract: a non-negative result (top bit clear) means the divisor fits.
  always_comb begin
    trial = trial_sub(rem, dvd[WIDTH-1], dvs);
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      dvd_nxt = {dvd[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = {rem[WIDTH-2:0], dvd[WIDTH-1]};
      dvd_nxt = {dvd[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      quo <= '0;
      rmd <= '0;
      dz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.B == '0) begin
              quo <= '1;
              rmd <= bus.A;
              dz  <= 1'b1;
            end else begin
              cnt <= CNT_FULL;
            end
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            quo <= neg_q ? neg2(dvd_nxt) : dvd_nxt;
            rmd <= neg_r ? neg2(rem_nxt) : rem_nxt;
            dz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Working registers carry no reset: they are always reloaded on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd   <= mag(bus.A);
      dvs   <= mag(bus.B);
      rem   <= '0;
      neg_q <= SIGNED_EN & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
      neg_r <= SIGNED_EN & bus.A[WIDTH-1];
    end else if (state == CALC) begin
      dvd <= dvd_nxt;
      rem <= rem_nxt;
    end
  end

  assign bus.ready    = (state == IDLE);
  assign bus.done     = (state == DONE);
  assign bus.Q        = quo;
  assign bus.R        = rmd;
  assign bus.div_zero = dz;

endmodule

// File: tb/tb_seq_div64.sv
// Bench for seq_div64: directed corner cases, reset abort, ignored start and random pairs
// against plain arithmetic division.
module tb_seq_div64;
  localparam int WIDTH = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_div64_if #(.WIDTH(WIDTH)) bus();
  seq_div64 #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!bus.ready && k < 300) begin
      step();
      k++;
    end
  endtask

  // Issue one request from IDLE and follow it to its done pulse (bounded).
  task automatic run_div(input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r,
                         output logic dz, output int lat, output bit ready_seen);
    int n;
    wait_ready();
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n = 1;
    ready_seen = 1'b0;
    while (!bus.done && n < 200) begin
      if (bus.ready) ready_seen = 1'b1;
      step();
      n++;
    end
    if (bus.ready) ready_seen = 1'b1;
    lat = bus.done ? n : -1;
    q   = bus.Q;
    r   = bus.R;
    dz  = bus.div_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) step();
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.Q !== 64'd0) begin bad++; $display("FAIL reset_q got=%h exp=0", bus.Q); end
    total++; if (bus.R !== 64'd0) begin bad++; $display("FAIL reset_r got=%h exp=0", bus.R); end
    total++; if (bus.div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", bus.div_zero); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [63:0] q, r;
    logic dz;
    int lat;
    bit rs;
    int k;
    run_div(64'd100, 64'd7, q, r, dz, lat, rs);
    total++; if (q !== 64'd14) begin bad++; $display("FAIL d100_7_q got=%0d exp=14", q); end
    total++; if (r !== 64'd2) begin bad++; $display("FAIL d100_7_r got=%0d exp=2", r); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL d100_7_dz got=%b exp=0", dz); end
    total++; if (lat !== 65) begin bad++; $display("FAIL d100_7_latency got=%0d exp=65", lat); end
    total++; if (rs !== 1'b0) begin bad++; $display("FAIL d100_7_ready_busy got=%b exp=0", rs); end

    run_div(64'd5, 64'd0, q, r, dz, lat, rs);
    total++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL dz_q got=%h exp=ffffffffffffffff", q); end
    total++; if (r !== 64'd5) begin bad++; $display("FAIL dz_r got=%0d exp=5", r); end
    total++; if (dz !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", dz); end
    total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency got=%0d exp=1", lat); end

    run_div(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, q, r, dz, lat, rs);
`ifndef DIV_SIGNED_EN
    total++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL max_1_q got=%h exp=ffffffffffffffff", q); end
    total++; if (r !== 64'd0) begin bad++; $display("FAIL max_1_r got=%h exp=0", r); end
    total++; if (dz !== 1'b0) begin bad++; $display("FAIL max_1_dz got=%b exp=0", dz); end
`endif

    // Q/R of the previous result must hold while the next division runs.
    wait_ready();
    bus.A = 64'd3;
    bus.B = 64'h8000_0000_0000_0000;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (k = 1; k < 10; k++) step();
    total++; if (bus.Q !== q) begin bad++; $display("FAIL hold_q_calc got=%h exp=%h", bus.Q, q); end
    k = 0;
    while (!bus.done && k < 200) begin step(); k++; end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL msb_div_done got=%b exp=1", bus.done); end
`ifndef DIV_SIGNED_EN
    total++; if (bus.Q !== 64'd0) begin bad++; $display("FAIL msb_div_q got=%h exp=0", bus.Q); end
    total++; if (bus.R !== 64'd3) begin bad++; $display("FAIL msb_div_r got=%h exp=3", bus.R); end
`endif
  endtask

  task automatic test_reset_mid_calc();
    logic [63:0] q, r;
    logic dz;
    int lat;
    bit rs, seen;
    wait_ready();
    bus.A = 64'd100;
    bus.B = 64'd7;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    seen = 1'b0;
    repeat (19) begin
      if (bus.done) seen = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", bus.ready); end
    total++; if (bus.Q !== 64'd0) begin bad++; $display("FAIL rstmid_q got=%h exp=0", bus.Q); end
    total++; if (bus.R !== 64'd0) begin bad++; $display("FAIL rstmid_r got=%h exp=0", bus.R); end
    total++; if ((bus.done | seen) !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", bus.done | seen); end
    step();
    run_div(64'd100, 64'd7, q, r, dz, lat, rs);
    total++; if (q !== 64'd14 || r !== 64'd2) begin bad++; $display("FAIL rstmid_rerun got=%0d/%0d exp=14/2", q, r); end
    total++; if (lat !== 65) begin bad++; $display("FAIL rstmid_latency got=%0d exp=65", lat); end
  endtask

  task automatic test_ignored_start();
    int pulses;
    logic [63:0] q, r;
    wait_ready();
    bus.A = 64'd100;
    bus.B = 64'd7;
    bus.start = 1'b1;
    step();
    bus.A = 64'd9;
    bus.B = 64'd3;
    pulses = 0;
    q = '0;
    r = '0;
    for (int cyc = 1; cyc <= 140; cyc++) begin
      if (cyc == 66) bus.start = 1'b0;
      if (bus.done) begin
        pulses++;
        q = bus.Q;
        r = bus.R;
      end
      step();
    end
    bus.start = 1'b0;
    total++; if (pulses !== 1) begin bad++; $display("FAIL busy_start_pulses got=%0d exp=1", pulses); end
    total++; if (q !== 64'd14 || r !== 64'd2) begin bad++; $display("FAIL busy_start_result got=%0d/%0d exp=14/2", q, r); end
  endtask

  task automatic test_random();
    logic [63:0] a, b, q, r, eq, er;
    logic dz;
    int lat;
    bit rs;
    for (int i = 0; i < 300; i++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      if (b == 64'd0) b = 64'd1;
      if (i % 7 == 0) a = a >> $urandom_range(0, 63);
`ifdef DIV_SIGNED_EN
      if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        eq = a; er = '0;
      end else begin
        eq = 64'($signed(a) / $signed(b));
        er = 64'($signed(a) % $signed(b));
      end
`else
      eq = a / b;
      er = a % b;
`endif
      run_div(a, b, q, r, dz, lat, rs);
      total++; if (q !== eq) begin bad++; $display("FAIL rand_q a=%h b=%h got=%h exp=%h", a, b, q, eq); end
      total++; if (r !== er) begin bad++; $display("FAIL rand_r a=%h b=%h got=%h exp=%h", a, b, r, er); end
      total++; if (lat !== 65) begin bad++; $display("FAIL rand_latency a=%h b=%h got=%0d exp=65", a, b, lat); end
      total++; if (dz !== 1'b0) begin bad++; $display("FAIL rand_dz got=%b exp=0", dz); end
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    logic [63:0] q, r;
    logic dz;
    int lat;
    bit rs;
    run_div(-64'sd7, 64'sd2, q, r, dz, lat, rs);
    total++; if (q !== -64'sd3 || r !== -64'sd1) begin bad++; $display("FAIL s_m7_2 got=%h/%h exp=-3/-1", q, r); end
    run_div(64'sd7, -64'sd2, q, r, dz, lat, rs);
    total++; if (q !== -64'sd3 || r !== 64'sd1) begin bad++; $display("FAIL s_7_m2 got=%h/%h exp=-3/1", q, r); end
    run_div(64'h8000_0000_0000_0000, -64'sd1, q, r, dz, lat, rs);
    total++; if (q !== 64'h8000_0000_0000_0000 || r !== 64'd0 || dz !== 1'b0) begin
      bad++; $display("FAIL s_min_m1 got=%h/%h/%b exp=8000000000000000/0/0", q, r, dz); end
    run_div(-64'sd5, 64'd0, q, r, dz, lat, rs);
    total++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF || r !== -64'sd5 || dz !== 1'b1) begin
      bad++; $display("FAIL s_dz got=%h/%h/%b exp=-1/-5/1", q, r, dz); end
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    rst = 1'b0;
    test_reset();
    test_directed();
    test_reset_mid_calc();
    test_ignored_start();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
